// File: rtl/pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Lock supervisor and reset sequencer for one PLL wrapper instance. It runs on
// the PLL reference clock, so it keeps working while the PLL output is absent.
// It pulses the PLL reset, waits for a filtered LOCK, retries on timeout
// (declaring a sticky fault after MAX_RETRY timeouts), and then releases the
// downstream active-low resets one after another. A lock loss or a forced
// relock after release pulls every downstream reset low and starts over.
//
// Ports
//   clkin1        in   reference clock, the only clock
//   rst_n         in   synchronous active-low reset
//   pll_lock      in   PLL LOCK, asynchronous (synchronised internally)
//   force_relock  in   single-cycle request to re-run the PLL reset sequence
//   pll_rst       out  active-high reset to the PLL
//   rst_n_out     out  sequenced active-low resets, bit 0 released first
//   ready         out  all resets released and PLL locked
//   fault         out  sticky: MAX_RETRY lock timeouts occurred
//   relock_cnt    out  lock losses / forced relocks after release, saturating
// ----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int NUM_RST          = 3,
    parameter int PLL_RST_CYC      = 32,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_FILT_CYC    = 1024,
    parameter int STAGE_GAP_CYC    = 16,
    parameter int MAX_RETRY        = 3
) (
    input  logic               clkin1,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               force_relock,
    output logic               pll_rst,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               ready,
    output logic               fault,
    output logic [7:0]         relock_cnt
);

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int TMAX = max4(PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_FILT_CYC, STAGE_GAP_CYC);
    localparam int TW   = $clog2(TMAX) + 1;

    // Terminal timer values: each state leaves on the edge where the timer
    // holds (cycle count - 1), since the timer is cleared on entry.
    localparam logic [TW-1:0] RST_END  = TW'(PLL_RST_CYC - 1);
    localparam logic [TW-1:0] TO_END   = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] FILT_END = TW'(LOCK_FILT_CYC - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(STAGE_GAP_CYC - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAIT_LOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t             state, state_nx;
    logic [TW-1:0]      timer, timer_nx;
    logic [3:0]         retry, retry_nx;
    logic [1:0]         sync;
    logic               lock_s;
    logic               pll_rst_nx;
    logic [NUM_RST-1:0] rst_n_out_nx;
    logic               ready_nx;
    logic               fault_nx;
    logic [7:0]         relock_nx;
    logic               abort;

    assign lock_s = sync[1];
    // After release, either a lost lock or a relock request tears the
    // sequence down; both together still count once.
    assign abort  = force_relock || !lock_s;

    always_comb begin
        state_nx     = state;
        timer_nx     = timer + TW'(1);
        retry_nx     = retry;
        pll_rst_nx   = pll_rst;
        rst_n_out_nx = rst_n_out;
        ready_nx     = ready;
        fault_nx     = fault;
        relock_nx    = relock_cnt;

        case (state)
            S_PLLRST: begin
                pll_rst_nx = 1'b1;
                if (timer == RST_END) begin
                    state_nx   = S_WAIT_LOCK;
                    timer_nx   = '0;
                    pll_rst_nx = 1'b0;
                end
            end

            S_WAIT_LOCK: begin
                if (force_relock) begin
                    state_nx   = S_PLLRST;
                    timer_nx   = '0;
                    pll_rst_nx = 1'b1;
                end else if (lock_s) begin
                    state_nx = S_FILTER;
                    timer_nx = '0;
                end else if (timer == TO_END) begin
                    retry_nx   = retry + 4'd1;
                    timer_nx   = '0;
                    pll_rst_nx = 1'b1;
                    if (retry_nx == RETRY_LIM) begin
                        state_nx = S_FAULT;
                        fault_nx = 1'b1;
                    end else begin
                        state_nx = S_PLLRST;
                    end
                end
            end

            S_FILTER: begin
                if (force_relock) begin
                    state_nx   = S_PLLRST;
                    timer_nx   = '0;
                    pll_rst_nx = 1'b1;
                end else if (!lock_s) begin
                    // Glitch: back to waiting with a fresh timeout window.
                    state_nx = S_WAIT_LOCK;
                    timer_nx = '0;
                end else if (timer == FILT_END) begin
                    state_nx     = S_RELEASE;
                    timer_nx     = '0;
                    retry_nx     = '0;
                    rst_n_out_nx = NUM_RST'(1);
                    if (rst_n_out_nx[NUM_RST-1]) begin
                        state_nx = S_RUN;
                        ready_nx = 1'b1;
                    end
                end
            end

            S_RELEASE: begin
                if (abort) begin
                    state_nx     = S_PLLRST;
                    timer_nx     = '0;
                    pll_rst_nx   = 1'b1;
                    rst_n_out_nx = '0;
                    ready_nx     = 1'b0;
                    if (relock_cnt != 8'hFF) relock_nx = relock_cnt + 8'd1;
                end else if (timer == GAP_END) begin
                    // Released bits form a thermometer code, so shifting in a
                    // one releases the next bit and keeps the order intact.
                    timer_nx     = '0;
                    rst_n_out_nx = (rst_n_out << 1) | NUM_RST'(1);
                    if (rst_n_out_nx[NUM_RST-1]) begin
                        state_nx = S_RUN;
                        ready_nx = 1'b1;
                    end
                end
            end

            S_RUN: begin
                timer_nx = timer;
                if (abort) begin
                    state_nx     = S_PLLRST;
                    timer_nx     = '0;
                    pll_rst_nx   = 1'b1;
                    rst_n_out_nx = '0;
                    ready_nx     = 1'b0;
                    if (relock_cnt != 8'hFF) relock_nx = relock_cnt + 8'd1;
                end
            end

            S_FAULT: begin
                timer_nx     = timer;
                pll_rst_nx   = 1'b1;
                rst_n_out_nx = '0;
                ready_nx     = 1'b0;
                fault_nx     = 1'b1;
                if (force_relock) begin
                    state_nx = S_PLLRST;
                    timer_nx = '0;
                    retry_nx = '0;
                    fault_nx = 1'b0;
                end
            end

            default: begin
                state_nx     = S_PLLRST;
                timer_nx     = '0;
                pll_rst_nx   = 1'b1;
                rst_n_out_nx = '0;
                ready_nx     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkin1) begin
        if (!rst_n) begin
            state      <= S_PLLRST;
            timer      <= '0;
            retry      <= '0;
            sync       <= '0;
            pll_rst    <= 1'b1;
            rst_n_out  <= '0;
            ready      <= 1'b0;
            fault      <= 1'b0;
            relock_cnt <= '0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            retry      <= retry_nx;
            sync       <= {sync[0], pll_lock};
            pll_rst    <= pll_rst_nx;
            rst_n_out  <= rst_n_out_nx;
            ready      <= ready_nx;
            fault      <= fault_nx;
            relock_cnt <= relock_nx;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Bench for pll_lock_supervisor with small parameters. A reference model
// tracks the supervisor phase and the edge at which each phase began, and
// derives every output from the phase and the elapsed time. Whenever the
// model's output vector changes it queues the new value with its cycle; a
// monitor pops one entry each time the DUT output vector changes. Directed
// phases cover bring-up, glitches, timeout/fault, lock loss, coincident
// events, saturation and mid-sequence reset; a random phase follows.
// ----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int NUM_RST = 3;
    localparam int RSTC    = 4;
    localparam int TOUT    = 64;
    localparam int FILT    = 8;
    localparam int GAP     = 2;
    localparam int MAXR    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic [2:0] rst_n_out;
    logic       ready;
    logic       fault;
    logic [7:0] relock_cnt;

    logic [13:0] dut_out;
    assign dut_out = {pll_rst, rst_n_out, ready, fault, relock_cnt};

    pll_lock_supervisor #(
        .NUM_RST(NUM_RST), .PLL_RST_CYC(RSTC), .LOCK_TIMEOUT_CYC(TOUT),
        .LOCK_FILT_CYC(FILT), .STAGE_GAP_CYC(GAP), .MAX_RETRY(MAXR)
    ) dut (
        .clkin1(clk), .rst_n(rst_n), .pll_lock(pll_lock), .force_relock(force_relock),
        .pll_rst(pll_rst), .rst_n_out(rst_n_out), .ready(ready), .fault(fault),
        .relock_cnt(relock_cnt)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [13:0] val;
    } exp_t;
    exp_t sbq[$];

    // ---------------- reference model ----------------
    localparam int M_PLLRST = 0, M_WAIT = 1, M_FILT = 2, M_REL = 3, M_RUN = 4, M_FAULT = 5;
    int   mode, t0, m_retry, m_relock;
    logic d1, d2;

    task automatic enter(input int m);
        mode = m;
        t0   = cyc;
    endtask

    initial begin : model
        int          e;
        int          nrel;
        logic        ls;
        logic [2:0]  rn;
        logic [13:0] v;
        logic [13:0] prev;
        prev = 'x;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                enter(M_PLLRST);
                m_retry = 0; m_relock = 0; d1 = 1'b0; d2 = 1'b0;
            end else begin
                ls = d2; d2 = d1; d1 = pll_lock;
                e = cyc - t0;
                case (mode)
                    M_PLLRST: if (e == RSTC) enter(M_WAIT);
                    M_WAIT: begin
                        if (force_relock) enter(M_PLLRST);
                        else if (ls) enter(M_FILT);
                        else if (e == TOUT) begin
                            m_retry++;
                            enter(m_retry == MAXR ? M_FAULT : M_PLLRST);
                        end
                    end
                    M_FILT: begin
                        if (force_relock) enter(M_PLLRST);
                        else if (!ls) enter(M_WAIT);
                        else if (e == FILT) begin
                            m_retry = 0;
                            enter(M_REL);
                        end
                    end
                    M_REL, M_RUN: begin
                        if (force_relock || !ls) begin
                            if (m_relock < 255) m_relock++;
                            enter(M_PLLRST);
                        end else if (mode == M_REL && e == (NUM_RST - 1) * GAP) begin
                            enter(M_RUN);
                        end
                    end
                    M_FAULT: if (force_relock) begin
                        m_retry = 0;
                        enter(M_PLLRST);
                    end
                    default: enter(M_PLLRST);
                endcase
            end
            rn = 3'b000;
            if (mode == M_REL) begin
                nrel = 1 + (cyc - t0) / GAP;
                rn = 3'((32'd1 << nrel) - 32'd1);
            end else if (mode == M_RUN) begin
                rn = 3'b111;
            end
            v = {(mode == M_PLLRST || mode == M_FAULT), rn, (mode == M_RUN),
                 (mode == M_FAULT), 8'(m_relock)};
            if (v !== prev) begin
                sbq.push_back('{cyc, v});
                prev = v;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [13:0] prev;
        exp_t        x;
        prev = 'x;
        forever begin
            @(negedge clk);
            if (dut_out !== prev) begin
                prev = dut_out;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected cyc=%0d got=%h want=no change", cyc, dut_out);
                end else begin
                    x = sbq.pop_front();
                    if (x.val !== dut_out || x.cyc != cyc) begin
                        errors++;
                        $display("FAIL sb_change got=%h@%0d want=%h@%0d", dut_out, cyc, x.val, x.cyc);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // sel: 0 rst_n_out[0], 1 ready, 2 fault, 3 rst_n_out==011
    task automatic wait_until(input int sel, input int bound, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = (rst_n_out[0] === 1'b1);
                1:       hit = (ready === 1'b1);
                2:       hit = (fault === 1'b1);
                default: hit = (rst_n_out === 3'b011);
            endcase
            if (hit) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL timeout sel=%0d got=no event want=event within %0d cycles", sel, bound);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=still running want=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int at, e_lock, last_rst, c, hold;

        cycles(3);
        check("reset_state", 32'(dut_out), 32'(14'b1_000_0_0_00000000));
        rst_n = 1'b1;
        last_rst = cyc;

        // T1 normal bring-up
        cycles(10);
        pll_lock = 1'b1;
        e_lock = cyc + 1;
        wait_until(0, 100, at);
        check("t1_rst0_time", 32'(at), 32'(e_lock + 2 + FILT));
        wait_until(1, 100, at);
        check("t1_ready_time", 32'(at), 32'(e_lock + 2 + FILT + (NUM_RST - 1) * GAP));
        check("t1_rst_all", 32'(rst_n_out), 32'h7);
        check("t1_relock", 32'(relock_cnt), 32'd0);

        // T4 lock loss in RUN for 3 cycles
        pll_lock = 1'b0;
        cycles(2);
        check("t4_still_ready", 32'(ready), 32'd1);
        cycles(1);
        check("t4_ready_drop", 32'(ready), 32'd0);
        check("t4_rst_drop", 32'(rst_n_out), 32'd0);
        check("t4_relock", 32'(relock_cnt), 32'd1);
        pll_lock = 1'b1;
        wait_until(1, 100, at);

        // T5a lock loss and force_relock seen in the same FSM cycle
        pll_lock = 1'b0;
        cycles(2);
        force_relock = 1'b1;
        cycles(1);
        force_relock = 1'b0;
        check("t5_single_inc", 32'(relock_cnt), 32'd2);
        check("t5_ready_drop", 32'(ready), 32'd0);

        // T2 filter glitch: 5 high, 1 low, then high
        cycles(6);
        pll_lock = 1'b1;
        cycles(5);
        pll_lock = 1'b0;
        cycles(1);
        pll_lock = 1'b1;
        e_lock = cyc + 1;
        wait_until(0, 100, at);
        check("t2_rst0_time", 32'(at), 32'(e_lock + 2 + FILT));
        wait_until(1, 100, at);

        // T5b saturation of relock_cnt
        for (int i = 0; i < 300; i++) begin
            wait_until(0, 100, at);
            cycles($urandom_range(0, 6));
            force_relock = 1'b1;
            cycles(1);
            force_relock = 1'b0;
        end
        check("t5_saturate", 32'(relock_cnt), 32'd255);

        // T6 reset in RELEASE with rst_n_out=011
        wait_until(3, 100, at);
        rst_n = 1'b0;
        cycles(1);
        check("t6_rst_out", 32'(rst_n_out), 32'd0);
        check("t6_pll_rst", 32'(pll_rst), 32'd1);
        check("t6_relock", 32'(relock_cnt), 32'd0);
        rst_n = 1'b1;
        pll_lock = 1'b0;
        last_rst = cyc;

        // T3 timeout to fault, then recovery by force_relock
        wait_until(2, 400, at);
        check("t3_fault_time", 32'(at), 32'(last_rst + MAXR * (RSTC + TOUT)));
        check("t3_fault_outs", 32'({pll_rst, rst_n_out, ready}), 32'b1_000_0);
        force_relock = 1'b1;
        cycles(1);
        force_relock = 1'b0;
        check("t3_fault_clear", 32'(fault), 32'd0);
        cycles(RSTC - 1);
        check("t3_pulse_high", 32'(pll_rst), 32'd1);
        cycles(1);
        check("t3_pulse_end", 32'(pll_rst), 32'd0);

        // Random phase
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            force_relock = 1'b0;
            rst_n = 1'b1;
            if (hold == 0) begin
                pll_lock = ($urandom_range(0, 2) != 0);
                hold = $urandom_range(1, 40);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 63) == 0) force_relock = 1'b1;
            if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
        end
        @(negedge clk);
        force_relock = 1'b0;
        rst_n = 1'b1;
        pll_lock = 1'b1;
        cycles(60);
        #2;
        c = sbq.size();
        check("sb_drained", 32'(c), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
